// File: rtl/iob_ram_dp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : iob_ram_dp_ctrl
//  Brief    : Initiator-side controller for the iob_ram_dp_be dual-port RAM.
//             Port A serves a read/write iob bus and emulates byte strobes
//             by read-modify-write on a RAM that only writes whole words.
//             Port B serves a read-only fetch bus, one read per cycle.
//             Optional macro IOB_RAM_DP_CTRL_COLLISION_FWD_EN forwards port A
//             write data to port B when both ports hit the same address.
//  Revision : 1.0 - initial release
// ============================================================================
module iob_ram_dp_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_valid,
  input  logic [ADDR_W-1:0]     a_addr,
  input  logic [DATA_W-1:0]     a_wdata,
  input  logic [DATA_W/8-1:0]   a_wstrb,
  output logic [DATA_W-1:0]     a_rdata,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [ADDR_W-1:0]     b_addr,
  output logic [DATA_W-1:0]     b_rdata,
  output logic                  b_ready,
  output logic                  mem_enA,
  output logic [DATA_W/8-1:0]   mem_weA,
  output logic [ADDR_W-1:0]     mem_addrA,
  output logic [DATA_W-1:0]     mem_dinA,
  input  logic [DATA_W-1:0]     mem_doutA,
  output logic                  mem_enB,
  output logic [ADDR_W-1:0]     mem_addrB,
  input  logic [DATA_W-1:0]     mem_doutB
);

  localparam int c_STRB_W = DATA_W / 8;

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_RD_WAIT = 3'd1;
  localparam logic [2:0] c_RD_RESP = 3'd2;
  localparam logic [2:0] c_RMW_WR  = 3'd3;
  localparam logic [2:0] c_RESP    = 3'd4;

  logic [2:0]          r_state;
  logic [2:0]          w_nextState;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [c_STRB_W-1:0] r_wstrb;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_bReady;

  logic                w_enA;
  logic [c_STRB_W-1:0] w_weA;
  logic [ADDR_W-1:0]   w_addrA;
  logic [DATA_W-1:0]   w_dinA;
  logic [DATA_W-1:0]   w_merge;
  logic                w_accept;

  assign w_accept = (r_state == c_IDLE) && a_valid;

  // Byte merge for RMW: strobed bytes from the request, others from the RAM word
  for (genvar i = 0; i < c_STRB_W; i++) begin : g_merge
    assign w_merge[i*8 +: 8] = r_wstrb[i] ? r_wdata[i*8 +: 8] : mem_doutA[i*8 +: 8];
  end

  // Port A next-state and RAM port A drive
  always_comb begin
    w_nextState = r_state;
    w_enA       = 1'b0;
    w_weA       = '0;
    w_addrA     = '0;
    w_dinA      = '0;
    case (r_state)
      c_IDLE: begin
        if (a_valid) begin
          w_enA   = 1'b1;
          w_addrA = a_addr;
          if (&a_wstrb) begin
            w_weA       = '1;
            w_dinA      = a_wdata;
            w_nextState = c_RESP;
          end else if (a_wstrb == '0) begin
            w_nextState = c_RD_WAIT;
          end else begin
            w_nextState = c_RMW_WR;
          end
        end
      end
      c_RD_WAIT: w_nextState = c_RD_RESP;
      c_RD_RESP: w_nextState = c_IDLE;
      c_RMW_WR: begin
        w_enA       = 1'b1;
        w_weA       = '1;
        w_addrA     = r_addr;
        w_dinA      = w_merge;
        w_nextState = c_RESP;
      end
      c_RESP:    w_nextState = c_IDLE;
      default:   w_nextState = c_IDLE;
    endcase
  end

  // Outputs that follow live inputs are gated so reset holds every pin at 0
  assign mem_enA   = w_enA & rst_n;
  assign mem_weA   = w_weA & {c_STRB_W{rst_n}};
  assign mem_addrA = w_addrA & {ADDR_W{rst_n}};
  assign mem_dinA  = w_dinA & {DATA_W{rst_n}};
  assign mem_enB   = b_valid & rst_n;
  assign mem_addrB = b_addr & {ADDR_W{rst_n}};

  assign a_ready = (r_state == c_RD_RESP) || (r_state == c_RESP);
  assign a_rdata = r_rdata;
  assign b_ready = r_bReady;

  // Port A state, request capture and read-data register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_addr  <= a_addr;
        r_wdata <= a_wdata;
        r_wstrb <= a_wstrb;
      end
      if (r_state == c_RD_WAIT) begin
        r_rdata <= mem_doutA;
      end
    end
  end

  // Port B completion tracks the request one cycle later (RAM latency)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bReady <= 1'b0;
    end else begin
      r_bReady <= b_valid;
    end
  end

`ifdef IOB_RAM_DP_CTRL_COLLISION_FWD_EN
  logic              r_fwd;
  logic [DATA_W-1:0] r_fwdData;
  logic              w_collision;

  assign w_collision = mem_enA && (mem_weA != '0) && mem_enB && (mem_addrA == mem_addrB);

  // Remember same-address write data so port B sees the new word, not RAM garbage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fwd     <= 1'b0;
      r_fwdData <= '0;
    end else begin
      r_fwd     <= w_collision;
      r_fwdData <= mem_dinA;
    end
  end

  assign b_rdata = r_bReady ? (r_fwd ? r_fwdData : mem_doutB) : '0;
`else
  assign b_rdata = r_bReady ? mem_doutB : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_iob_ram_dp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iob_ram_dp_ctrl
//  Brief    : Scoreboard bench for iob_ram_dp_ctrl with a behavioural
//             read-first dual-port RAM model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_iob_ram_dp_ctrl;

  logic        clk;
  logic        rst_n;
  logic        a_valid;
  logic [9:0]  a_addr;
  logic [31:0] a_wdata;
  logic [3:0]  a_wstrb;
  logic [31:0] a_rdata;
  logic        a_ready;
  logic        b_valid;
  logic [9:0]  b_addr;
  logic [31:0] b_rdata;
  logic        b_ready;
  logic        mem_enA;
  logic [3:0]  mem_weA;
  logic [9:0]  mem_addrA;
  logic [31:0] mem_dinA;
  logic [31:0] mem_doutA;
  logic        mem_enB;
  logic [9:0]  mem_addrB;
  logic [31:0] mem_doutB;

  iob_ram_dp_ctrl #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_wdata(a_wdata), .a_wstrb(a_wstrb),
    .a_rdata(a_rdata), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_rdata(b_rdata), .b_ready(b_ready),
    .mem_enA(mem_enA), .mem_weA(mem_weA), .mem_addrA(mem_addrA),
    .mem_dinA(mem_dinA), .mem_doutA(mem_doutA),
    .mem_enB(mem_enB), .mem_addrB(mem_addrB), .mem_doutB(mem_doutB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first RAM model: a same-cycle port B read sees the old word
  logic [31:0] ram [0:1023];
  always @(posedge clk) begin
    if (mem_enA) begin
      if (mem_weA != 4'h0) ram[mem_addrA] <= mem_dinA;
      mem_doutA <= ram[mem_addrA];
    end
    if (mem_enB) mem_doutB <= ram[mem_addrB];
  end

  int nChecks = 0;
  int nFails  = 0;
  logic [31:0] lastRead = 32'h0;

  logic [31:0] qA [$];
  logic [31:0] qB [$];
  logic [41:0] qW [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] kv(input int i);
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  // Monitor: pops expectations whenever the DUT presents a response or RAM write
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_enA && mem_weA != 4'h0) begin
        if (qW.size() == 0) begin
          nChecks++; nFails++;
          $display("FAIL unexpected_write: addr 0x%03h data 0x%08h, none required", mem_addrA, mem_dinA);
        end else begin
          logic [41:0] e;
          e = qW.pop_front();
          check("write_addr", {22'h0, mem_addrA}, {22'h0, e[41:32]});
          check("write_data", mem_dinA, e[31:0]);
          check("write_we", {28'h0, mem_weA}, 32'hF);
        end
      end
      if (a_ready) begin
        if (qA.size() == 0) begin
          nChecks++; nFails++;
          $display("FAIL unexpected_a_ready: a_rdata 0x%08h, no response required", a_rdata);
        end else begin
          check("a_rdata", a_rdata, qA.pop_front());
        end
      end
      if (b_ready) begin
        if (qB.size() == 0) begin
          nChecks++; nFails++;
          $display("FAIL unexpected_b_ready: b_rdata 0x%08h, no response required", b_rdata);
        end else begin
          check("b_rdata", b_rdata, qB.pop_front());
        end
      end else begin
        check("b_rdata_idle", b_rdata, 32'h0);
      end
    end
  end

  // Port A transaction, called one step after a rising edge with the DUT idle
  task automatic portA(input logic [9:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input int expLat, input string name);
    int n;
    a_valid = 1'b1; a_addr = addr; a_wdata = wdata; a_wstrb = strb;
    @(posedge clk); #1;
    n = 1;
    while (!a_ready && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'(expLat));
    a_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [9:0] addr, input logic [31:0] data);
    qW.push_back({addr, data});
    qA.push_back(lastRead);
    portA(addr, data, 4'hF, 1, "full_write");
  endtask

  task automatic rd(input logic [9:0] addr, input logic [31:0] exp);
    lastRead = exp;
    qA.push_back(exp);
    portA(addr, 32'h0, 4'h0, 2, "read");
  endtask

  task automatic pwr(input logic [9:0] addr, input logic [31:0] data,
                     input logic [3:0] strb, input logic [31:0] merged);
    qW.push_back({addr, merged});
    qA.push_back(lastRead);
    portA(addr, data, strb, 2, "partial_write");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] collExp;
    rst_n = 1'b0; a_valid = 1'b1; a_addr = 10'h3FF; a_wdata = 32'hFFFF_FFFF;
    a_wstrb = 4'hF; b_valid = 1'b1; b_addr = 10'h3FF;
    #12;
    check("rst_mem_enA", {31'h0, mem_enA}, 32'h0);
    check("rst_mem_weA", {28'h0, mem_weA}, 32'h0);
    check("rst_mem_addrA", {22'h0, mem_addrA}, 32'h0);
    check("rst_mem_dinA", mem_dinA, 32'h0);
    check("rst_mem_enB", {31'h0, mem_enB}, 32'h0);
    check("rst_mem_addrB", {22'h0, mem_addrB}, 32'h0);
    check("rst_a_ready", {31'h0, a_ready}, 32'h0);
    check("rst_a_rdata", a_rdata, 32'h0);
    check("rst_b_ready", {31'h0, b_ready}, 32'h0);
    check("rst_b_rdata", b_rdata, 32'h0);
    a_valid = 1'b0; b_valid = 1'b0; a_wstrb = 4'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) wr(10'(i), kv(i));

    // Full write then read back
    wr(10'h005, 32'hDEAD_BEEF);
    rd(10'h005, 32'hDEAD_BEEF);

    // Byte-strobe write via RMW
    pwr(10'h005, 32'h1122_3344, 4'b0101, 32'hDE22_BE44);
    rd(10'h005, 32'hDE22_BE44);
    pwr(10'h005, 32'h99AA_BBCC, 4'b1000, 32'h9922_BE44);
    rd(10'h005, 32'h9922_BE44);

    // Port B streaming, one read per cycle
    for (int i = 0; i < 4; i++) begin
      b_valid = 1'b1; b_addr = 10'(i);
      qB.push_back(kv(i));
      @(posedge clk); #1;
      check("b_ready_stream", {31'h0, b_ready}, 32'h1);
    end
    b_valid = 1'b0;
    @(posedge clk); #1;
    check("b_ready_drop", {31'h0, b_ready}, 32'h0);

    // Same-address collision between port A write and port B read
    wr(10'h010, 32'hAAAA_5555);
`ifdef IOB_RAM_DP_CTRL_COLLISION_FWD_EN
    collExp = 32'h1234_5678;
`else
    collExp = 32'hAAAA_5555;
`endif
    qW.push_back({10'h010, 32'h1234_5678});
    qA.push_back(lastRead);
    qB.push_back(collExp);
    a_valid = 1'b1; a_addr = 10'h010; a_wdata = 32'h1234_5678; a_wstrb = 4'hF;
    b_valid = 1'b1; b_addr = 10'h010;
    @(posedge clk); #1;
    b_valid = 1'b0;
    check("coll_a_ready", {31'h0, a_ready}, 32'h1);
    a_valid = 1'b0;
    @(posedge clk); #1;
    rd(10'h010, 32'h1234_5678);
    rd(10'h002, kv(2));

    // Reset asserted while an RMW write is pending
    wr(10'h020, 32'h0BAD_F00D);
    a_valid = 1'b1; a_addr = 10'h020; a_wdata = 32'hFFFF_FFFF; a_wstrb = 4'b0011;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_mem_enA", {31'h0, mem_enA}, 32'h0);
    check("midrst_mem_weA", {28'h0, mem_weA}, 32'h0);
    check("midrst_mem_dinA", mem_dinA, 32'h0);
    check("midrst_a_ready", {31'h0, a_ready}, 32'h0);
    check("midrst_a_rdata", a_rdata, 32'h0);
    a_valid = 1'b0; a_wstrb = 4'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    lastRead = 32'h0;
    @(posedge clk); #1;
    check("midrst_ram_untouched", ram[10'h020], 32'h0BAD_F00D);
    check("postrst_a_rdata", a_rdata, 32'h0);
    rd(10'h020, 32'h0BAD_F00D);
    rd(10'h005, 32'h9922_BE44);

    repeat (3) @(posedge clk);
    #1;
    check("qA_empty", 32'(qA.size()), 32'h0);
    check("qB_empty", 32'(qB.size()), 32'h0);
    check("qW_empty", 32'(qW.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iob_ram_dp_ctrl.md
Name: iob_ram_dp_ctrl

Overview:
- Initiator-side controller for the dual-port SRAM wrapper `iob_ram_dp_be`; sits between two native (iob) slave buses and the RAM's port A / port B pins.
- The RAM applies whole-word writes only: `wmask` is fixed, and the byte write-enable bus collapses to a single write strobe.
- Port A (read/write bus): this block performs read-modify-write to emulate byte strobes.
- Port B (read-only fetch bus): pipelined reads, one per cycle.
- RAM read data appears one cycle after enable.

Parameters:
- ADDR_W, 10, word address width; must equal the RAM's ADDR_W.
- DATA_W, 32, data width; must be a multiple of 8.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- a_valid  in  1  port A request
- a_addr  in  ADDR_W  port A word address
- a_wdata  in  DATA_W  port A write data
- a_wstrb  in  DATA_W/8  byte strobes; 0 = read
- a_rdata  out  DATA_W  port A read data, registered
- a_ready  out  1  port A one-cycle completion pulse
- b_valid  in  1  port B read request
- b_addr  in  ADDR_W  port B word address
- b_rdata  out  DATA_W  port B read data
- b_ready  out  1  port B completion pulse
- mem_enA  out  1  to RAM enA
- mem_weA  out  DATA_W/8  to RAM weA; all-ones = write, 0 = read
- mem_addrA  out  ADDR_W  to RAM addrA
- mem_dinA  out  DATA_W  to RAM dinA
- mem_doutA  in  DATA_W  from RAM doutA
- mem_enB  out  1  to RAM enB
- mem_addrB  out  ADDR_W  to RAM addrB
- mem_doutB  in  DATA_W  from RAM doutB

Behaviour:
- Reset: while rst_n is low, every output is forced to 0.
  - State goes to IDLE.
  - Request registers (addr, wdata, wstrb) clear.
  - Any in-flight transaction is dropped; a write pending in RMW_WR is not issued.
- Port A FSM states: IDLE, RD_WAIT, RD_RESP, RMW_WR, RESP.
- IDLE:
  - a_valid=0: mem_enA=0.
  - a_valid=1: request is accepted this cycle; a_addr, a_wdata and a_wstrb are registered; mem_enA=1; mem_addrA=a_addr.
- Read (a_wstrb=0):
  - Accept cycle: mem_weA=0; go to RD_WAIT.
  - RD_WAIT: a_rdata<=mem_doutA; go to RD_RESP.
  - RD_RESP: a_ready=1; go to IDLE.
  - Latency: a_ready rises 2 cycles after accept.
- Full write (a_wstrb all ones):
  - Accept cycle: mem_weA=all ones; mem_dinA=a_wdata; go to RESP.
  - RESP: a_ready=1; go to IDLE.
  - Latency: 1 cycle.
- Partial write (a_wstrb neither 0 nor all ones):
  - Accept cycle: read issued, mem_weA=0; go to RMW_WR.
  - RMW_WR: mem_enA=1; mem_weA=all ones; mem_addrA=registered addr.
  - Merge: mem_dinA byte i = wstrb_reg[i] ? wdata_reg byte i : mem_doutA byte i. Go to RESP.
  - Latency: 2 cycles.
- a_valid outside IDLE is ignored, not queued; the requester holds a_valid until it sees a_ready.
- IDLE is re-entered the cycle after a_ready, so the maximum rate is one transaction per 2 (write) or 3 (read/RMW) cycles.
- a_rdata holds its last read value across writes; it changes only in RD_WAIT.
- Port B (pipelined, no stall):
  - mem_enB=b_valid; mem_addrB=b_addr, combinational.
  - b_ready<=b_valid, registered.
  - b_rdata = b_ready ? mem_doutB : 0.
  - Back-to-back b_valid yields back-to-back b_ready.
- Collision: a port A RAM write and a port B read to the same address in the same cycle. The RAM returns undefined port B data; see Optional Feature.
- No ordering guarantee between ports except through the Optional Feature.

Optional Feature:
- Macro: IOB_RAM_DP_CTRL_COLLISION_FWD_EN.
- Defined:
  - A cycle with mem_enA & mem_weA≠0 & mem_enB & mem_addrA==mem_addrB sets a registered fwd flag and captures mem_dinA.
  - In the following cycle b_rdata = captured data instead of mem_doutB.
  - Flag clears after one cycle and on reset.
- Undefined: no detection logic; b_rdata always passes mem_doutB through on collision.

Test Plan:
- Reset then idle: rst_n low mid-RMW_WR → mem_enA=0 immediately, no write issued; all outputs 0 until first request after release.
- Full write addr 0x005 data 0xDEADBEEF, then read 0x005 → write a_ready 1 cycle after accept; read a_ready 2 cycles after accept with a_rdata=0xDEADBEEF.
- Partial write: word 0x005=0xDEADBEEF, a_wstrb=4'b0101, a_wdata=0x11223344 → RAM read then write 0xDE22BE44; a_ready 2 cycles after accept; readback 0xDE22BE44.
- Port B streaming: b_valid held 4 cycles at addr 0,1,2,3 → b_ready high 4 consecutive cycles with words 0..3; b_rdata=0 when b_ready=0.
- a_valid held through busy states → exactly one transaction per a_ready; no duplicate RAM write observed on mem_enA.
- Collision: port A full write 0x12345678 to 0x010 same cycle as b_addr=0x010 → with COLLISION_FWD_EN, b_rdata=0x12345678 next cycle; without it, b_rdata equals mem_doutB.
